// File: rtl/rv32_writeback_unit.sv
// rv32_writeback_unit: merges ALU results and a single outstanding load
// response onto the register file write port, applies load byte/halfword
// extension, suppresses x0 writes and tracks pending-load destinations.
module rv32_writeback_unit #(
    parameter int unsigned ALU_FIFO_DEPTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        alu_valid_in,
    input  logic [4:0]  alu_rd_addr_in,
    input  logic [31:0] alu_data_in,
    output logic        alu_ready_out,
    input  logic        ld_issue_in,
    input  logic [4:0]  ld_issue_rd_in,
    input  logic [2:0]  ld_issue_funct3_in,
    input  logic [1:0]  ld_issue_offset_in,
    output logic        ld_issue_ready_out,
    input  logic        ld_resp_valid_in,
    input  logic [31:0] ld_resp_data_in,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic [31:0] busy_mask_out
);

    localparam int unsigned PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        LD_IDLE,
        LD_PEND
    } ld_state_t;

    ld_state_t   ld_state;
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_funct3_q;
    logic [1:0]  ld_offset_q;
    logic        ld_ready_q;
    logic [31:0] busy_q;
    logic        live_q;

    logic [4:0]       fifo_rd   [ALU_FIFO_DEPTH];
    logic [31:0]      fifo_data [ALU_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    logic        sel_load;
    logic        alu_accept;
    logic        fifo_pop;
    logic        fifo_push;
    logic        bypass;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign fifo_empty         = (fifo_count == '0);
    assign fifo_full          = (fifo_count == CNT_W'(ALU_FIFO_DEPTH));
    assign alu_ready_out      = live_q && !fifo_full;
    assign ld_issue_ready_out = ld_ready_q;
    assign busy_mask_out      = busy_q;

    // Tracks that the block has left reset so ready flags stay low while held.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) live_q <= 1'b0;
        else           live_q <= 1'b1;
    end

    // Load FSM: latches issue context, owns ready flag and busy scoreboard.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            ld_state    <= LD_IDLE;
            ld_rd_q     <= '0;
            ld_funct3_q <= '0;
            ld_offset_q <= '0;
            ld_ready_q  <= 1'b0;
            busy_q      <= '0;
        end else begin
            case (ld_state)
                LD_IDLE: begin
                    ld_ready_q <= 1'b1;
                    if (ld_issue_in && ld_ready_q) begin
                        ld_rd_q     <= ld_issue_rd_in;
                        ld_funct3_q <= ld_issue_funct3_in;
                        ld_offset_q <= ld_issue_offset_in;
                        ld_ready_q  <= 1'b0;
                        ld_state    <= LD_PEND;
                        if (ld_issue_rd_in != 5'd0)
                            busy_q[ld_issue_rd_in] <= 1'b1;
                    end
                end
                LD_PEND: begin
                    if (ld_resp_valid_in) begin
                        busy_q[ld_rd_q] <= 1'b0;
                        ld_ready_q      <= 1'b1;
                        ld_state        <= LD_IDLE;
                    end
                end
                default: ld_state <= LD_IDLE;
            endcase
        end
    end

    // Byte/halfword lane selection and sign/zero extension of the load word.
    always_comb begin
        ld_byte = '0;
        case (ld_offset_q)
            2'd0: ld_byte = ld_resp_data_in[7:0];
            2'd1: ld_byte = ld_resp_data_in[15:8];
            2'd2: ld_byte = ld_resp_data_in[23:16];
            2'd3: ld_byte = ld_resp_data_in[31:24];
            default: ld_byte = '0;
        endcase
        ld_half = ld_offset_q[1] ? ld_resp_data_in[31:16] : ld_resp_data_in[15:0];
        case (ld_funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_resp_data_in;
        endcase
    end

    // Write-port arbitration: load response, then FIFO head, then bypass.
    always_comb begin
        sel_load   = (ld_state == LD_PEND) && ld_resp_valid_in;
        alu_accept = alu_valid_in && alu_ready_out;
        fifo_pop   = !sel_load && !fifo_empty;
        bypass     = !sel_load && fifo_empty && alu_accept;
        fifo_push  = alu_accept && !bypass;
        wb_valid   = sel_load || fifo_pop || bypass;
        wb_rd      = '0;
        wb_data    = '0;
        if (sel_load) begin
            wb_rd   = ld_rd_q;
            wb_data = ld_ext;
        end else if (fifo_pop) begin
            wb_rd   = fifo_rd[rd_ptr];
            wb_data = fifo_data[rd_ptr];
        end else if (bypass) begin
            wb_rd   = alu_rd_addr_in;
            wb_data = alu_data_in;
        end
    end

    // ALU result buffer; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                fifo_rd[wr_ptr]   <= alu_rd_addr_in;
                fifo_data[wr_ptr] <= alu_data_in;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Registered write port; x0 writes are consumed without a pulse.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_en_out   <= 1'b0;
            rd_addr_out <= '0;
            rd_out      <= '0;
        end else begin
            wr_en_out <= 1'b0;
            if (wb_valid && (wb_rd != 5'd0)) begin
                wr_en_out   <= 1'b1;
                rd_addr_out <= wb_rd;
                rd_out      <= wb_data;
            end
        end
    end

endmodule
